instr_loader: RTL
=================

# instr_loader

Boot-time program loader that writes instruction words into the single-cycle CPU's instruction memory while holding the CPU in reset. It accepts a byte stream over a valid/ready handshake: a 16-bit word count followed by that many little-endian 32-bit instructions. It drives the instruction-memory write port, then releases the CPU. It is the write side of the instruction-memory interface, which the CPU's fetch stage only reads.

## Interface
- DATA_WIDTH, 32, instruction word width; fixed at 32 (4 bytes per word)
- ADDR_WIDTH, 8, instruction-memory word-address width; depth = 2^ADDR_WIDTH words
- clk  input  1  system clock, all state updates on rising edge
- rst  input  1  asynchronous, active-high reset
- in_data  input  8  stream byte
- in_valid  input  1  in_data is valid
- in_ready  output  1  loader accepts a byte this cycle
- reload  input  1  one-cycle request to start a new load; honoured only in RUN
- mem_we  output  1  instruction-memory write enable, one-cycle pulse per word
- mem_waddr  output  ADDR_WIDTH  word address of the write
- mem_wdata  output  DATA_WIDTH  instruction word to write
- cpu_hold  output  1  drives the CPU's rst; high while loading
- done  output  1  high in RUN (program loaded, CPU running)
- overflow  output  1  sticky: word count exceeded memory depth during the last load

## Operation
- A byte transfers on a rising edge where in_valid && in_ready.
- in_ready = 1 in LEN_LO, LEN_HI, DATA; 0 in FLUSH and RUN. It is decoded from the state register only and never depends on in_valid.
- States:
  - LEN_LO: capture count[7:0], go to LEN_HI.
  - LEN_HI: capture count[15:8]. If the full count is 0, go to FLUSH, otherwise go to DATA. Clear the word index and byte index.
  - DATA: shift the byte into the assembly register at lane byte_idx (byte 0 → bits 7:0, little-endian). Increment byte_idx (2-bit, wraps).
    - On the 4th byte, register mem_wdata = assembled word and mem_waddr = word_idx[ADDR_WIDTH-1:0].
    - Also on the 4th byte: pulse mem_we next cycle if word_idx < 2^ADDR_WIDTH; otherwise suppress the write and set overflow. Then increment word_idx (16-bit).
    - If word_idx+1 == count, go to FLUSH.
  - FLUSH: one cycle (the final mem_we pulse occurs here); go to RUN.
  - RUN: cpu_hold = 0, done = 1. reload = 1 → LEN_LO, cpu_hold = 1, done = 0, overflow cleared.
- reload is ignored in every state except RUN.
- The count is a word count (unsigned, 0–65535). Words beyond the memory depth are consumed from the stream but never written, so the memory image never wraps onto low addresses.
- Partial words at stream end: the loader waits indefinitely in DATA. Only rst or a completed word advances it.

## Timing
- Reset (async, immediate), all values held while rst = 1:
  - state = LEN_LO, in_ready = 1
  - cpu_hold = 1, done = 0, overflow = 0
  - mem_we = 0, mem_waddr = 0, mem_wdata = 0
  - counters = 0
- Write latency: mem_we/mem_waddr/mem_wdata are valid in the cycle after the edge that accepted a word's 4th byte. mem_we is high for exactly 1 cycle. mem_waddr/mem_wdata hold until the next word.
- Back-to-back bytes at full rate: no bubbles. A write pulse overlaps acceptance of the next word's byte 0.
- Release: the edge accepting the final byte enters FLUSH (mem_we = 1 during FLUSH). The next edge enters RUN, so cpu_hold falls 1 cycle after the last write. For count = 0, the sequence is LEN_HI → FLUSH → RUN with no writes.
- cpu_hold and done are registered, glitch-free, and exact complements.
- rst mid-load: immediately back to LEN_LO with cpu_hold = 1. Memory contents already written are left as is; no further writes occur.

## Test plan
- Reset: assert rst mid-cycle → asynchronously cpu_hold = 1, done = 0, mem_we = 0, in_ready = 1. Release, then idle 10 cycles → no writes.
- Two-word load at full rate: bytes 02 00 | 13 05 10 00 | 73 00 10 00 →
  - mem_we pulses at addr 0 with 0x00100513
  - mem_we pulses at addr 1 with 0x00100073
  - cpu_hold falls exactly 1 cycle after the second pulse; done = 1; in_ready = 0.
- Backpressure-free gaps: same stream with in_valid dropped for random 0–3 cycles between bytes → identical writes and data. No byte is accepted while in_valid = 0.
- Zero count: bytes 00 00 → no mem_we; done = 1 two cycles after the LEN_HI byte.
- Overflow with ADDR_WIDTH = 2: count 5, words 0x11111111..0x55555555 →
  - writes to addr 0–3 only; 5th word consumed with no mem_we
  - overflow = 1 and done = 1
  - reload then clears overflow and raises cpu_hold.
- Reload/ignore: reload pulsed during DATA → no effect. In RUN, reload → next cycle in_ready = 1 and cpu_hold = 1. A new 1-word load 0xDEADBEEF writes addr 0.

Source files
------------

// File: rtl/instr_loader_if.sv
// Stream-in / instruction-memory-write bundle for the boot loader.
// master drives the byte stream and reload; slave is the loader itself.
interface instr_loader_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 8
);
    logic [7:0]            in_data;
    logic                  in_valid;
    logic                  in_ready;
    logic                  reload;
    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] mem_waddr;
    logic [DATA_WIDTH-1:0] mem_wdata;
    logic                  cpu_hold;
    logic                  done;
    logic                  overflow;

    modport master (
        output in_data, in_valid, reload,
        input  in_ready, mem_we, mem_waddr, mem_wdata, cpu_hold, done, overflow
    );

    modport slave (
        input  in_data, in_valid, reload,
        output in_ready, mem_we, mem_waddr, mem_wdata, cpu_hold, done, overflow
    );
endinterface

// File: rtl/instr_loader.sv
// Boot loader: takes a 16-bit word count plus little-endian 32-bit words from a
// byte stream, writes them to instruction memory, then releases the CPU.
module instr_loader #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 8
) (
    input  logic          clk,
    input  logic          rst,
    instr_loader_if.slave bus
);
    typedef enum logic [2:0] {
        LEN_LO,
        LEN_HI,
        DATA,
        FLUSH,
        RUN
    } state_t;

    state_t                state;
    state_t                state_n;
    logic [15:0]           count;
    logic [15:0]           word_idx;
    logic [1:0]            byte_idx;
    logic [DATA_WIDTH-9:0] asm_word;
    logic                  in_ready;
    logic                  accept;
    logic                  last_word;

    // Words at or beyond the memory depth are swallowed instead of wrapping.
    function automatic logic in_range(input logic [15:0] idx);
        return (idx >> ADDR_WIDTH) == 16'd0;
    endfunction

    assign in_ready     = (state == LEN_LO) || (state == LEN_HI) || (state == DATA);
    assign accept       = bus.in_valid && in_ready;
    assign last_word    = ({1'b0, word_idx} + 17'd1) == {1'b0, count};
    assign bus.in_ready = in_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= LEN_LO;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n = state;
        case (state)
            LEN_LO: begin
                if (accept) state_n = LEN_HI;
            end
            LEN_HI: begin
                if (accept) state_n = ({bus.in_data, count[7:0]} == 16'd0) ? FLUSH : DATA;
            end
            DATA: begin
                if (accept && byte_idx == 2'd3 && last_word) state_n = FLUSH;
            end
            FLUSH: begin
                state_n = RUN;
            end
            RUN: begin
                if (bus.reload) state_n = LEN_LO;
            end
            default: begin
                state_n = LEN_LO;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count         <= '0;
            word_idx      <= '0;
            byte_idx      <= '0;
            asm_word      <= '0;
            bus.mem_we    <= 1'b0;
            bus.mem_waddr <= '0;
            bus.mem_wdata <= '0;
            bus.overflow  <= 1'b0;
            bus.cpu_hold  <= 1'b1;
            bus.done      <= 1'b0;
        end else begin
            bus.mem_we   <= 1'b0;
            // Both derived from the next state so they are registered complements.
            bus.cpu_hold <= (state_n != RUN);
            bus.done     <= (state_n == RUN);
            case (state)
                LEN_LO: begin
                    if (accept) count[7:0] <= bus.in_data;
                end
                LEN_HI: begin
                    if (accept) begin
                        count[15:8] <= bus.in_data;
                        word_idx    <= '0;
                        byte_idx    <= '0;
                    end
                end
                DATA: begin
                    if (accept) begin
                        byte_idx <= byte_idx + 2'd1;
                        if (byte_idx == 2'd3) begin
                            bus.mem_wdata <= {bus.in_data, asm_word};
                            bus.mem_waddr <= word_idx[ADDR_WIDTH-1:0];
                            if (in_range(word_idx)) begin
                                bus.mem_we <= 1'b1;
                            end else begin
                                bus.overflow <= 1'b1;
                            end
                            word_idx <= word_idx + 16'd1;
                        end else begin
                            case (byte_idx)
                                2'd0:    asm_word[7:0]   <= bus.in_data;
                                2'd1:    asm_word[15:8]  <= bus.in_data;
                                default: asm_word[23:16] <= bus.in_data;
                            endcase
                        end
                    end
                end
                RUN: begin
                    if (bus.reload) bus.overflow <= 1'b0;
                end
                default: begin
                end
            endcase
        end
    end
endmodule
